// File: rtl/kyber512_dec_pkg.sv
// Shared constants and types for the Kyber512 decapsulation loader.
// Holds the bus widths, the frame word counts and the loader FSM state encoding.
package kyber512_dec_pkg;

  localparam int unsigned CT_W = 5888;
  localparam int unsigned SK_W = 13056;
  localparam int unsigned SS_W = 256;
  localparam int unsigned DW   = 32;

  localparam int unsigned CT_WORDS    = CT_W / DW;              // 184
  localparam int unsigned SK_WORDS    = SK_W / DW;              // 408
  localparam int unsigned FRAME_WORDS = CT_WORDS + SK_WORDS;    // 592
  localparam int unsigned SS_WORDS    = SS_W / DW;              // 8

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/kyber_ss_serializer.sv
// Shared-secret serializer: captures a wide shared secret and the verify-fail flag,
// then emits it least-significant word first on a valid/ready stream.
// Ports: load/ss_in/fail_in capture a result; m_valid/m_ready/m_data/m_last/m_fail
// form the result stream, with m_fail held for the whole frame.
module kyber_ss_serializer #(
  parameter int unsigned SS_W = 256,
  parameter int unsigned DW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SS_W-1:0] ss_in,
  input  logic            fail_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic            m_fail
);

  localparam int unsigned BEATS = SS_W / DW;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [SS_W-1:0] sh;
  logic [BW-1:0]   beat;

  // Head of the shift register is the current beat; it only moves on a handshake.
  assign m_data = sh[DW-1:0];

  // Capture, shift on accept, and raise m_last one beat ahead of the final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      beat    <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_fail  <= 1'b0;
    end else if (load) begin
      sh      <= ss_in;
      beat    <= '0;
      m_valid <= 1'b1;
      m_last  <= (BEATS == 1);
      m_fail  <= fail_in;
    end else if (m_valid && m_ready) begin
      sh <= sh >> DW;
      if (m_last) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        beat    <= '0;
      end else begin
        beat   <= beat + BW'(1);
        m_last <= (beat == BW'(BEATS - 2));
      end
    end
  end

endmodule

// File: rtl/kyber512_dec_loader.sv
// Word-serial loader/unloader around the Kyber512 decapsulation core.
// Ports: s_* input frame stream (ciphertext then secret key, 32-bit words);
// o_Ct/o_SK wide core inputs; o_enable start pulse; i_done/i_fail/i_ss core result;
// m_* result stream with m_fail; o_busy (not in LOAD); o_err one-cycle error pulse.
module kyber512_dec_loader #(
  parameter int unsigned CT_W    = 5888,
  parameter int unsigned SK_W    = 13056,
  parameter int unsigned SS_W    = 256,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 131071
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  output logic [CT_W-1:0] o_Ct,
  output logic [SK_W-1:0] o_SK,
  output logic            o_enable,
  input  logic            i_done,
  input  logic            i_fail,
  input  logic [SS_W-1:0] i_ss,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic            m_fail,
  output logic            o_busy,
  output logic            o_err
);

  import kyber512_dec_pkg::state_e;
  import kyber512_dec_pkg::LOAD;
  import kyber512_dec_pkg::START;
  import kyber512_dec_pkg::WAIT;
  import kyber512_dec_pkg::DRAIN;

  localparam int unsigned CT_N    = CT_W / DW;
  localparam int unsigned FRAME_N = CT_N + SK_W / DW;
  localparam int unsigned CNT_W   = $clog2(FRAME_N);
  localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned CT_IW   = $clog2(CT_W);
  localparam int unsigned SK_IW   = $clog2(SK_W);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WD_W-1:0]  wd, wd_n;
  logic             err_n, enable_n, cap;
  logic             accept, last_word, ct_sel;
  logic [CT_IW-1:0] ct_base;
  logic [SK_IW-1:0] sk_base;

  assign accept    = (state == LOAD) && s_valid && s_ready;
  assign last_word = (cnt == CNT_W'(FRAME_N - 1));
  assign ct_sel    = (cnt < CNT_W'(CT_N));
  // Word address to bit offset; the SK offset is only used once cnt >= CT_N.
  assign ct_base   = CT_IW'(32'(cnt) * DW);
  assign sk_base   = SK_IW'((32'(cnt) - CT_N) * DW);

  // Next-state and next-output decode.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wd_n     = wd;
    err_n    = 1'b0;
    enable_n = 1'b0;
    cap      = 1'b0;
    unique case (state)
      LOAD: begin
        if (accept) begin
          if (s_last != last_word) begin
            // Early s_last or a missing s_last on the final word: drop the frame.
            err_n = 1'b1;
            cnt_n = '0;
          end else if (last_word) begin
            state_n  = START;
            enable_n = 1'b1;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      START: begin
        state_n = WAIT;
        wd_n    = '0;
      end
      WAIT: begin
        if (i_done) begin
          cap     = 1'b1;
          state_n = DRAIN;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th WAIT cycle without a result.
          err_n   = 1'b1;
          wd_n    = '0;
          state_n = LOAD;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end
      DRAIN: begin
        if (m_valid && m_ready && m_last) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // State, counters, registered status outputs and the wide operand buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= '0;
      wd       <= '0;
      s_ready  <= 1'b0;
      o_busy   <= 1'b0;
      o_enable <= 1'b0;
      o_err    <= 1'b0;
      o_Ct     <= '0;
      o_SK     <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wd       <= wd_n;
      s_ready  <= (state_n == LOAD);
      o_busy   <= (state_n != LOAD);
      o_enable <= enable_n;
      o_err    <= err_n;
      if (accept && ct_sel)  o_Ct[ct_base +: DW] <= s_data;
      if (accept && !ct_sel) o_SK[sk_base +: DW] <= s_data;
    end
  end

  kyber_ss_serializer #(
    .SS_W (SS_W),
    .DW   (DW)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cap),
    .ss_in   (i_ss),
    .fail_in (i_fail),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_fail  (m_fail)
  );

endmodule

// File: tb/tb_kyber512_dec_loader.sv
// Directed-plus-random bench for kyber512_dec_loader with a behavioural core model.
module tb_kyber512_dec_loader;

  localparam int unsigned TO = 50;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [31:0]    s_data = '0;
  logic           s_last = 1'b0;
  logic [5887:0]  o_Ct;
  logic [13055:0] o_SK;
  logic           o_enable;
  logic           i_done = 1'b0;
  logic           i_fail = 1'b0;
  logic [255:0]   i_ss = '0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [31:0]    m_data;
  logic           m_last;
  logic           m_fail;
  logic           o_busy;
  logic           o_err;

  always #5 clk = ~clk;

  kyber512_dec_loader #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .o_Ct(o_Ct), .o_SK(o_SK), .o_enable(o_enable),
    .i_done(i_done), .i_fail(i_fail), .i_ss(i_ss),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_fail(m_fail), .o_busy(o_busy), .o_err(o_err)
  );

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  int err_cnt = 0;

  logic [31:0] ct_w [184];
  logic [31:0] sk_w [408];
  logic [31:0] exp_q [$];
  logic        exp_fail;

  always @(posedge clk) begin
    if (o_enable) en_cnt <= en_cnt + 1;
    if (o_err)    err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_frame();
    foreach (ct_w[k]) ct_w[k] = $urandom;
    foreach (sk_w[k]) sk_w[k] = $urandom;
  endtask

  // One input beat, optionally preceded by an idle cycle carrying junk.
  task automatic send_word(input logic [31:0] d, input logic last);
    int guard = 0;
    logic rdy;
    if ($urandom_range(0, 7) == 0) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      s_last  = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      rdy = s_ready;
      tick();
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) chk("s_ready_wait", 64'd0, 64'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int last_at, input int nwords);
    for (int i = 0; i < nwords; i++)
      send_word((i < 184) ? ct_w[i] : sk_w[i - 184], i == last_at);
  endtask

  task automatic check_buses(input string tag);
    int bad = 0;
    for (int k = 0; k < 184; k++) if (o_Ct[k*32 +: 32] !== ct_w[k]) bad++;
    for (int k = 0; k < 408; k++) if (o_SK[k*32 +: 32] !== sk_w[k]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  // Core model: called in the o_enable cycle S, raises i_done during cycle S+k.
  task automatic core_respond(input int k, input logic [255:0] ss, input logic fail);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(ss[i*32 +: 32]);
    exp_fail = fail;
    i_ss   = ss;
    i_fail = fail;
    repeat (k) tick();
    chk("wait_m_valid", 64'(m_valid), 64'd0);
    chk("wait_busy", 64'(o_busy), 64'd1);
    chk("wait_s_ready", 64'(s_ready), 64'd0);
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    i_ss   = ~ss;
    i_fail = ~fail;
  endtask

  // Accept nbeats result words; mode 0 always ready, 1 toggling, 2 random.
  task automatic receive(input int nbeats, input int mode);
    int beat = 0;
    int guard = 0;
    logic acc;
    while (beat < nbeats && guard < 200) begin
      chk("m_valid", 64'(m_valid), 64'd1);
      chk("m_data", 64'(m_data), 64'(exp_q[beat]));
      chk("m_last", 64'(m_last), 64'(beat == 7));
      chk("m_fail", 64'(m_fail), 64'(exp_fail));
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (guard % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      acc = m_valid && m_ready;
      tick();
      if (acc) beat++;
      guard++;
    end
    m_ready = 1'b0;
    if (beat < nbeats) chk("drain_timeout", 64'(beat), 64'(nbeats));
  endtask

  task automatic full_frame(input int lat, input logic [255:0] ss, input logic fail,
                            input int mode);
    int e0;
    gen_frame();
    e0 = en_cnt;
    send_frame(591, 592);
    chk("enable_n_plus_1", 64'(o_enable), 64'd1);
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_s_ready", 64'(s_ready), 64'd0);
    check_buses("buses_at_start");
    core_respond(lat, ss, fail);
    receive(8, mode);
    chk("post_m_valid", 64'(m_valid), 64'd0);
    chk("post_busy", 64'(o_busy), 64'd0);
    chk("post_s_ready", 64'(s_ready), 64'd1);
    chk("enable_count", 64'(en_cnt - e0), 64'd1);
    check_buses("buses_held");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_enable"}, 64'(o_enable), 64'd0);
    chk({tag, "_err"}, 64'(o_err), 64'd0);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_last"}, 64'(m_last), 64'd0);
    chk({tag, "_m_data"}, 64'(m_data), 64'd0);
    chk({tag, "_m_fail"}, 64'(m_fail), 64'd0);
    chk({tag, "_ct_zero"}, 64'(o_Ct === '0), 64'd1);
    chk({tag, "_sk_zero"}, 64'(o_SK === '0), 64'd1);
  endtask

  initial begin
    int e0;
    int r0;
    logic [255:0] kat_ss;

    // Reset values, then s_ready rises one edge after release.
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", 64'(s_ready), 64'd0);
    tick();
    chk("s_ready_after_release", 64'(s_ready), 64'd1);
    chk("busy_after_release", 64'(o_busy), 64'd0);

    // Known-answer style frame with a fixed shared secret.
    kat_ss = {4{64'h0123456789ABCDEF}};
    full_frame(40, kat_ss, 1'b0, 0);

    // i_done outside WAIT has no effect.
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    tick();
    chk("done_in_load_m_valid", 64'(m_valid), 64'd0);
    chk("done_in_load_busy", 64'(o_busy), 64'd0);

    // Early s_last on word 100.
    gen_frame();
    e0 = en_cnt;
    r0 = err_cnt;
    send_frame(100, 101);
    chk("early_last_err", 64'(o_err), 64'd1);
    chk("early_last_busy", 64'(o_busy), 64'd0);
    tick();
    chk("early_last_err_pulse", 64'(o_err), 64'd0);
    chk("early_last_err_count", 64'(err_cnt - r0), 64'd1);
    chk("early_last_no_enable", 64'(en_cnt - e0), 64'd0);
    full_frame(int'($urandom_range(1, 49)), {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom}, 1'b0, 0);

    // Word 591 without s_last.
    gen_frame();
    e0 = en_cnt;
    send_frame(-1, 592);
    chk("missing_last_err", 64'(o_err), 64'd1);
    chk("missing_last_busy", 64'(o_busy), 64'd0);
    chk("missing_last_enable", 64'(o_enable), 64'd0);
    tick();
    chk("missing_last_no_enable", 64'(en_cnt - e0), 64'd0);

    // Watchdog: no i_done, abort after TO WAIT cycles.
    gen_frame();
    send_frame(591, 592);
    chk("timeout_enable", 64'(o_enable), 64'd1);
    for (int i = 1; i <= int'(TO); i++) begin
      tick();
      if (o_err !== 1'b0 || m_valid !== 1'b0) chk("timeout_early", 64'(i), 64'd0);
    end
    tick();
    chk("timeout_err", 64'(o_err), 64'd1);
    chk("timeout_s_ready", 64'(s_ready), 64'd1);
    chk("timeout_busy", 64'(o_busy), 64'd0);
    chk("timeout_m_valid", 64'(m_valid), 64'd0);
    tick();
    chk("timeout_err_pulse", 64'(o_err), 64'd0);

    // Backpressure with i_fail set, then i_done on the last permitted WAIT cycle.
    full_frame(int'($urandom_range(1, 49)), {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom}, 1'b1, 1);
    full_frame(int'(TO), {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 2);

    // Random frames.
    for (int n = 0; n < 3; n++)
      full_frame(int'($urandom_range(1, 49)), {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 2);

    // Reset in the middle of LOAD.
    gen_frame();
    send_frame(-1, 300);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_load");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_load_s_ready", 64'(s_ready), 64'd1);

    // Reset in the middle of DRAIN after four beats.
    gen_frame();
    send_frame(591, 592);
    core_respond(10, {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom}, 1'b1);
    receive(4, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_drain");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_valid !== 1'b0) chk("rst_drain_m_valid", 64'(m_valid), 64'd0);
    end
    chk("rst_drain_s_ready", 64'(s_ready), 64'd1);

    // Fresh frame after reset.
    full_frame(int'($urandom_range(1, 49)), {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom}, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
